// File: rtl/mult_share_ctrl.sv
// Two-requester sequencer for one shared combinational multiplier: round-robin
// grant, registered operands, SETTLE-cycle hold, then product capture and response.
module mult_share_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           req1_ready,
  output logic           resp0_valid,
  output logic           resp1_valid,
  output logic [2*N-1:0] resp_p,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_p,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic       last;
  logic       owner;
  logic [3:0] cnt;
  logic       grant;
  logic       hs;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    hs         = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (req0_valid && req1_valid) grant = ~last;
        else                          grant = req1_valid;
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        hs         = req0_ready || req1_ready;
        if (hs) state_nxt = WAIT;
      end
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      cnt    <= 4'd0;
      mul_a  <= '0;
      mul_b  <= '0;
      resp_p <= '0;
      busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (hs) begin
            mul_a <= grant ? req1_a : req0_a;
            mul_b <= grant ? req1_b : req0_b;
            owner <= grant;
            last  <= grant;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt    <= cnt - 4'd1;
          else             resp_p <= mul_p;
        end
        default: ;
      endcase
    end
  end

  assign resp0_valid = (state == RESP) && !owner;
  assign resp1_valid = (state == RESP) && owner;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: one instance with SETTLE=1, one with SETTLE=3,
// each wired to a behavioural N x N multiplier.
module tb_mult_share_ctrl;

  logic       clk;
  logic       resetn;

  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic       resp0_valid, resp1_valid, busy;
  logic [7:0] resp_p, mul_p;

  logic       req0_valid_s3, req1_valid_s3, req0_ready_s3, req1_ready_s3;
  logic [3:0] req0_a_s3, req0_b_s3, req1_a_s3, req1_b_s3, mul_a_s3, mul_b_s3;
  logic       resp0_valid_s3, resp1_valid_s3, busy_s3;
  logic [7:0] resp_p_s3, mul_p_s3;

  int n_chk  = 0;
  int n_pass = 0;

  assign mul_p    = {4'b0, mul_a} * {4'b0, mul_b};
  assign mul_p_s3 = {4'b0, mul_a_s3} * {4'b0, mul_b_s3};

  mult_share_ctrl #(.N(4), .SETTLE(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_p(resp_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  mult_share_ctrl #(.N(4), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid_s3), .req0_a(req0_a_s3), .req0_b(req0_b_s3), .req0_ready(req0_ready_s3),
    .req1_valid(req1_valid_s3), .req1_a(req1_a_s3), .req1_b(req1_b_s3), .req1_ready(req1_ready_s3),
    .resp0_valid(resp0_valid_s3), .resp1_valid(resp1_valid_s3), .resp_p(resp_p_s3),
    .mul_a(mul_a_s3), .mul_b(mul_b_s3), .mul_p(mul_p_s3), .busy(busy_s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_resp_p", 32'(resp_p), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp0", 32'(resp0_valid), 0);
    check("rst_resp1", 32'(resp1_valid), 0);
    resetn = 1'b1;
  endtask

  // Per-requester operand queues for the contention run, with hand-computed products.
  logic [3:0] a0 [4] = '{4'd3, 4'd0, 4'd15, 4'd15};
  logic [3:0] b0 [4] = '{4'd5, 4'd15, 4'd15, 4'd0};
  logic [7:0] p0 [4] = '{8'd15, 8'd0, 8'd225, 8'd0};
  logic [3:0] a1 [4] = '{4'd15, 4'd9, 4'd1, 4'd15};
  logic [3:0] b1 [4] = '{4'd15, 4'd7, 4'd1, 4'd14};
  logic [7:0] p1 [4] = '{8'd225, 8'd63, 8'd1, 8'd210};

  logic [3:0] ba [3] = '{4'd0, 4'd15, 4'd15};
  logic [3:0] bb [3] = '{4'd15, 4'd15, 4'd0};
  logic [7:0] bp [3] = '{8'd0, 8'd225, 8'd0};

  initial begin
    int i0, i1, g;
    logic [3:0] ea, eb;
    logic [7:0] ep, prev;

    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_valid_s3 = 1'b0; req1_valid_s3 = 1'b0;
    req0_a_s3 = '0; req0_b_s3 = '0; req1_a_s3 = '0; req1_b_s3 = '0;
    tick();

    // Single request (13,11) on the SETTLE=1 instance
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd11;
    #1;
    check("single_ready0", 32'(req0_ready), 1);
    check("single_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("single_mul_a", 32'(mul_a), 13);
    check("single_mul_b", 32'(mul_b), 11);
    check("single_busy_c1", 32'(busy), 1);
    check("single_resp0_c1", 32'(resp0_valid), 0);
    tick();
    check("single_resp0", 32'(resp0_valid), 1);
    check("single_resp1", 32'(resp1_valid), 0);
    check("single_resp_p", 32'(resp_p), 143);
    tick();
    check("single_busy_c3", 32'(busy), 0);
    check("single_resp0_c3", 32'(resp0_valid), 0);

    // Simultaneous first requests and continuous contention
    do_reset();
    i0 = 0; i1 = 0;
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0];
    for (int k = 0; k < 8; k++) begin
      g = k % 2;
      #1;
      check("cont_ready0", 32'(req0_ready), 32'(g == 0));
      check("cont_ready1", 32'(req1_ready), 32'(g == 1));
      ea = (g == 0) ? a0[i0] : a1[i1];
      eb = (g == 0) ? b0[i0] : b1[i1];
      ep = (g == 0) ? p0[i0] : p1[i1];
      tick();
      check("cont_mul_a", 32'(mul_a), 32'(ea));
      check("cont_mul_b", 32'(mul_b), 32'(eb));
      check("cont_busy", 32'(busy), 1);
      if (g == 0) begin
        i0++;
        if (i0 < 4) begin req0_a = a0[i0]; req0_b = b0[i0]; end
        else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 4) begin req1_a = a1[i1]; req1_b = b1[i1]; end
        else req1_valid = 1'b0;
      end
      #1;
      check("cont_wait_ready0", 32'(req0_ready), 0);
      check("cont_wait_ready1", 32'(req1_ready), 0);
      tick();
      check("cont_resp0", 32'(resp0_valid), 32'(g == 0));
      check("cont_resp1", 32'(resp1_valid), 32'(g == 1));
      check("cont_resp_p", 32'(resp_p), 32'(ep));
      check("cont_resp_ready0", 32'(req0_ready), 0);
      check("cont_resp_ready1", 32'(req1_ready), 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset mid-operation
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2;
    #1;
    check("rmid_ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    resetn = 1'b0;
    tick();
    check("rmid_resp0", 32'(resp0_valid), 0);
    check("rmid_mul_a", 32'(mul_a), 0);
    check("rmid_mul_b", 32'(mul_b), 0);
    check("rmid_resp_p", 32'(resp_p), 0);
    check("rmid_busy", 32'(busy), 0);
    resetn = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    #1;
    check("rmid_tie_ready0", 32'(req0_ready), 1);
    check("rmid_tie_ready1", 32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rmid_no_resp0", 32'(resp0_valid), 0);
    check("rmid_idle_busy", 32'(busy), 0);

    // Boundary operands from requester 0 alone; resp_p must hold between captures
    prev = 8'd0;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_a = ba[k]; req0_b = bb[k];
      #1;
      check("bnd_ready0", 32'(req0_ready), 1);
      tick();
      req0_valid = 1'b0;
      check("bnd_hold_wait", 32'(resp_p), 32'(prev));
      tick();
      check("bnd_resp0", 32'(resp0_valid), 1);
      check("bnd_resp_p", 32'(resp_p), 32'(bp[k]));
      tick();
      check("bnd_hold_idle", 32'(resp_p), 32'(bp[k]));
      prev = bp[k];
    end

    // SETTLE=3 instance: req1 (9,7) with req0 knocking during the operation
    req1_valid_s3 = 1'b1; req1_a_s3 = 4'd9; req1_b_s3 = 4'd7;
    #1;
    check("s3_ready1", 32'(req1_ready_s3), 1);
    tick();
    req1_valid_s3 = 1'b0;
    req0_valid_s3 = 1'b1; req0_a_s3 = 4'd1; req0_b_s3 = 4'd2;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("s3_mul_a", 32'(mul_a_s3), 9);
      check("s3_mul_b", 32'(mul_b_s3), 7);
      check("s3_busy", 32'(busy_s3), 1);
      check("s3_ready0_wait", 32'(req0_ready_s3), 0);
      check("s3_resp1_early", 32'(resp1_valid_s3), 0);
      tick();
    end
    #1;
    check("s3_resp1", 32'(resp1_valid_s3), 1);
    check("s3_resp0", 32'(resp0_valid_s3), 0);
    check("s3_resp_p", 32'(resp_p_s3), 63);
    check("s3_ready0_resp", 32'(req0_ready_s3), 0);
    tick();
    #1;
    check("s3_idle_busy", 32'(busy_s3), 0);
    check("s3_idle_resp1", 32'(resp1_valid_s3), 0);
    check("s3_idle_ready0", 32'(req0_ready_s3), 1);
    req0_valid_s3 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencer and round-robin arbiter that shares one combinational N×N array multiplier between two requesters. Each accepted request has its operands registered onto the multiplier inputs, waits a fixed settle time, then captures the 2N-bit product and returns it to the requester that issued it. Sits between the requesting datapaths and a single external multiplier instance.

## Interface
- N, 4: operand width; the product is 2N bits.
- SETTLE, 1: number of cycles the multiplier inputs are held stable before the product is sampled. Legal range 1..15.

- clk, in, 1: clock; all state changes on the rising edge.
- resetn, in, 1: synchronous reset, active-low.
- req0_valid, in, 1: requester 0 has operands available.
- req0_a, req0_b, in, N each: requester 0 operands.
- req0_ready, out, 1: requester 0 handshake accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- resp0_valid, out, 1: single-cycle pulse; resp_p holds requester 0's product.
- resp1_valid, out, 1: single-cycle pulse; resp_p holds requester 1's product.
- resp_p, out, 2N: captured product.
- mul_a, mul_b, out, N each: registered operands driven to the shared multiplier.
- mul_p, in, 2N: product returned by the shared multiplier (combinational).
- busy, out, 1: high whenever state is not IDLE.

## Operation
- **Clock and reset.** One clock (clk). resetn is synchronous and active-low; it is sampled on the clk rising edge.
- **States:** IDLE, WAIT, RESP.
- **IDLE.**
  - Arbitration is combinational from reqX_valid and the last-grant pointer `last`.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not `last`.
  - req_ready of the granted requester is 1; the other is 0.
  - A handshake is valid && ready. On a handshake:
    - mul_a/mul_b ← the granted requester's operands.
    - owner ← granted id; last ← granted id.
    - cnt ← SETTLE−1; state → WAIT.
  - No valid: remain in IDLE.
- **WAIT.**
  - Both req_ready signals are 0.
  - mul_a/mul_b are held stable.
  - If cnt ≠ 0, cnt decrements.
  - If cnt = 0, resp_p ← mul_p and state → RESP.
- **RESP.**
  - resp{owner}_valid = 1 for exactly this cycle.
  - state → IDLE.
  - No request is accepted in RESP.
- **Held outputs.** resp_p holds its value until the next capture. mul_a/mul_b hold the last operands until the next handshake.
- **Arithmetic.** Operands are unsigned. resp_p is the full 2N-bit mul_p with no truncation. The block does not check mul_p; it trusts the multiplier.
- **Requester obligations.** A requester must hold valid and its operands stable until it sees ready. Dropping valid before ready is legal; the request is simply not taken.
- **Reset values.**
  - state = IDLE, last = 1 (so requester 0 wins the first tie), owner = 0, cnt = 0.
  - mul_a = mul_b = 0, resp_p = 0, busy = 0.
  - resp0_valid = resp1_valid = 0.
  - req0_ready and req1_ready follow the IDLE arbitration rule once out of reset.
- **Reset during an operation.** The in-flight operation is discarded. No resp_valid pulse is issued, and all registers take their reset values.

## Timing
- A handshake in cycle 0 gives:
  - mul_a/mul_b valid in cycles 1..SETTLE (WAIT).
  - mul_p sampled at the end of cycle SETTLE.
  - respX_valid and the new resp_p in cycle SETTLE+1 (RESP).
  - The next possible handshake in cycle SETTLE+2.
- Latency from handshake to response: SETTLE+1 cycles. Throughput: one product per SETTLE+2 cycles.
- busy is 1 in cycles 1..SETTLE+1 and is registered.
- req_ready is combinational from valid, state and last; it is never 1 outside IDLE.
- Both requesters continuously valid: grants alternate 0,1,0,1 with no starvation. Each waits at most one operation.

## Test plan
- **Single request, N=4, SETTLE=1.** req0 a=4'd13, b=4'd11 in cycle 0.
  - Required: req0_ready=1 in cycle 0; mul_a=13, mul_b=11 in cycle 1.
  - Required: resp0_valid=1 with resp_p=8'd143 in cycle 2; busy=0 in cycle 3.
- **Simultaneous first requests.** req0 (3,5) and req1 (15,15) both valid from reset release.
  - Required: req0 granted first; resp0_valid with resp_p=15.
  - Required: req1 then granted at the next IDLE; resp1_valid with resp_p=225.
- **Continuous contention.** Both requesters valid for 8 operations.
  - Required: grant order 0,1,0,1,0,1,0,1; each response pulse goes only to its owner; exactly one pulse per grant.
- **Settle time, SETTLE=3.** req1 (9,7).
  - Required: mul_a/mul_b stable for cycles 1-3; resp1_valid=1 with resp_p=63 in cycle 4.
  - Required: a valid req0 presented during cycles 1-4 sees req0_ready=0.
- **Reset mid-operation.** resetn=0 in cycle 1 after a req0 (2,2) handshake.
  - Required: no resp0_valid; mul_a=mul_b=0, resp_p=0, busy=0.
  - Required: the next tie after reset is granted to requester 0.
- **Boundary operands.** (0,15) then (15,15), then (15,0).
  - Required: resp_p = 0, 225, 0 respectively.
  - Required: resp_p holds 225 until the third capture, and upper bits are never truncated.
